// File: rtl/chimera_widemem_bypass_ctrl.sv
// chimera_widemem_bypass_ctrl: sequences wide-memory bypass mode switches by draining the wide AXI port,
// and limits outstanding AW/AR transactions.
module chimera_widemem_bypass_ctrl #(
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned SettleCycles   = 4,
    parameter bit          BypassRstVal   = 1'b0,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            soc_clk_i,
    input  logic            rst_i,
    input  logic            bypass_req_i,
    output logic            bypass_o,
    output logic            busy_o,
    output logic            done_o,
    input  logic            mst_aw_valid_i,
    output logic            mst_aw_ready_o,
    output logic            slv_aw_valid_o,
    input  logic            slv_aw_ready_i,
    input  logic            mst_ar_valid_i,
    output logic            mst_ar_ready_o,
    output logic            slv_ar_valid_o,
    input  logic            slv_ar_ready_i,
    input  logic            b_valid_i,
    input  logic            b_ready_i,
    input  logic            r_valid_i,
    input  logic            r_ready_i,
    input  logic            r_last_i,
    output logic [CntW-1:0] aw_cnt_o,
    output logic [CntW-1:0] ar_cnt_o
);
    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_e;

    state_e          state_q, state_d;
    logic            bypass_q, bypass_d;
    logic            done_q, done_d;
    logic [7:0]      settle_q, settle_d;
    logic [CntW-1:0] aw_cnt_q, aw_cnt_d, ar_cnt_q, ar_cnt_d;
    logic            aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
    logic            aw_open, ar_open, aw_hs, ar_hs, b_hs, r_hs;

    assign b_hs = b_valid_i & b_ready_i;
    assign r_hs = r_valid_i & r_ready_i & r_last_i;

    // A stalled request keeps its channel open so valid is never withdrawn.
    assign aw_open = aw_hold_q | (state_q == IDLE && (aw_cnt_q < CntW'(MaxOutstanding) || b_hs));
    assign ar_open = ar_hold_q | (state_q == IDLE && (ar_cnt_q < CntW'(MaxOutstanding) || r_hs));

    assign slv_aw_valid_o = aw_open & mst_aw_valid_i;
    assign mst_aw_ready_o = aw_open & slv_aw_ready_i;
    assign slv_ar_valid_o = ar_open & mst_ar_valid_i;
    assign mst_ar_ready_o = ar_open & slv_ar_ready_i;

    assign aw_hs = slv_aw_valid_o & slv_aw_ready_i;
    assign ar_hs = slv_ar_valid_o & slv_ar_ready_i;

    always_comb begin
        aw_cnt_d  = aw_cnt_q;
        ar_cnt_d  = ar_cnt_q;
        aw_hold_d = slv_aw_valid_o & ~slv_aw_ready_i;
        ar_hold_d = slv_ar_valid_o & ~slv_ar_ready_i;
        if (aw_hs && !b_hs) aw_cnt_d = aw_cnt_q + CntW'(1);
        else if (!aw_hs && b_hs && aw_cnt_q != '0) aw_cnt_d = aw_cnt_q - CntW'(1);
        if (ar_hs && !r_hs) ar_cnt_d = ar_cnt_q + CntW'(1);
        else if (!ar_hs && r_hs && ar_cnt_q != '0) ar_cnt_d = ar_cnt_q - CntW'(1);
    end

    always_comb begin
        state_d  = state_q;
        bypass_d = bypass_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE:   if (bypass_req_i != bypass_q) state_d = DRAIN;
            DRAIN: begin
                if (bypass_req_i == bypass_q) state_d = IDLE;
                else if (aw_cnt_q == '0 && ar_cnt_q == '0 && !aw_hold_q && !ar_hold_q) state_d = SWITCH;
            end
            SWITCH: begin
                bypass_d = ~bypass_q;
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == 8'(SettleCycles)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bypass_q  <= BypassRstVal;
            done_q    <= 1'b0;
            settle_q  <= '0;
            aw_cnt_q  <= '0;
            ar_cnt_q  <= '0;
            aw_hold_q <= 1'b0;
            ar_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bypass_q  <= bypass_d;
            done_q    <= done_d;
            settle_q  <= settle_d;
            aw_cnt_q  <= aw_cnt_d;
            ar_cnt_q  <= ar_cnt_d;
            aw_hold_q <= aw_hold_d;
            ar_hold_q <= ar_hold_d;
        end
    end

    // Responses without a matching outstanding request are a protocol error.
    a_no_b_underflow: assert property (@(posedge soc_clk_i) disable iff (rst_i)
        !(b_hs && !aw_hs && aw_cnt_q == '0));
    a_no_r_underflow: assert property (@(posedge soc_clk_i) disable iff (rst_i)
        !(r_hs && !ar_hs && ar_cnt_q == '0));

    assign bypass_o = bypass_q;
    assign busy_o   = state_q != IDLE;
    assign done_o   = done_q;
    assign aw_cnt_o = aw_cnt_q;
    assign ar_cnt_o = ar_cnt_q;
endmodule

// File: tb/tb_chimera_widemem_bypass_ctrl.sv
// tb_chimera_widemem_bypass_ctrl: directed checks of mode switching, draining and outstanding limits.
module tb_chimera_widemem_bypass_ctrl;
    logic       soc_clk_i = 1'b0, rst_i = 1'b1, bypass_req_i = 1'b0;
    logic       bypass_o, busy_o, done_o;
    logic       mst_aw_valid_i = 1'b0, mst_aw_ready_o, slv_aw_valid_o, slv_aw_ready_i = 1'b0;
    logic       mst_ar_valid_i = 1'b0, mst_ar_ready_o, slv_ar_valid_o, slv_ar_ready_i = 1'b0;
    logic       b_valid_i = 1'b0, b_ready_i = 1'b0;
    logic       r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
    logic [3:0] aw_cnt_o, ar_cnt_o;
    int         n_tests = 0, n_fail = 0;

    chimera_widemem_bypass_ctrl dut (
        .soc_clk_i(soc_clk_i), .rst_i(rst_i), .bypass_req_i(bypass_req_i),
        .bypass_o(bypass_o), .busy_o(busy_o), .done_o(done_o),
        .mst_aw_valid_i(mst_aw_valid_i), .mst_aw_ready_o(mst_aw_ready_o),
        .slv_aw_valid_o(slv_aw_valid_o), .slv_aw_ready_i(slv_aw_ready_i),
        .mst_ar_valid_i(mst_ar_valid_i), .mst_ar_ready_o(mst_ar_ready_o),
        .slv_ar_valid_o(slv_ar_valid_o), .slv_ar_ready_i(slv_ar_ready_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .aw_cnt_o(aw_cnt_o), .ar_cnt_o(ar_cnt_o)
    );

    always #5 soc_clk_i = ~soc_clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge soc_clk_i);
        #1;
    endtask

    // From the flip edge: SETTLE lasts SettleCycles+1 cycles, then done pulses.
    task automatic expect_settle_done(input string tag);
        for (int i = 0; i < 4; i++) begin
            tick();
            check({tag, "_settle_busy"}, busy_o, 1);
        end
        tick();
        check({tag, "_done"}, done_o, 1);
        check({tag, "_idle"}, busy_o, 0);
        tick();
        check({tag, "_done_pulse"}, done_o, 0);
    endtask

    initial begin
        tick(2);
        rst_i = 1'b0;
        check("rst_bypass", bypass_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_aw_cnt", aw_cnt_o, 0);
        check("rst_ar_cnt", ar_cnt_o, 0);
        mst_aw_valid_i = 1'b1;
        #1;
        check("rst_aw_pass_valid", slv_aw_valid_o, 1);
        mst_aw_valid_i = 1'b0;

        // Fill reads to the limit, then a same-cycle R-last lets one more in.
        mst_ar_valid_i = 1'b1;
        slv_ar_ready_i = 1'b1;
        tick(8);
        check("ar_full_cnt", ar_cnt_o, 8);
        check("ar_full_blk_valid", slv_ar_valid_o, 0);
        check("ar_full_blk_ready", mst_ar_ready_o, 0);
        {r_valid_i, r_ready_i, r_last_i} = 3'b111;
        #1;
        check("ar_swap_valid", slv_ar_valid_o, 1);
        tick();
        check("ar_swap_cnt", ar_cnt_o, 8);
        mst_ar_valid_i = 1'b0;
        r_last_i = 1'b0;
        tick();
        check("r_nolast_cnt", ar_cnt_o, 8);
        r_last_i = 1'b1;
        tick(6);
        check("r_drain_cnt", ar_cnt_o, 2);
        {r_valid_i, r_ready_i, r_last_i} = 3'b000;

        // Request withdrawn while draining: no flip, no done.
        bypass_req_i = 1'b1;
        tick();
        check("cancel_drain_busy", busy_o, 1);
        bypass_req_i = 1'b0;
        tick();
        check("cancel_idle", busy_o, 0);
        check("cancel_bypass", bypass_o, 0);
        check("cancel_done", done_o, 0);
        {r_valid_i, r_ready_i, r_last_i} = 3'b111;
        tick(2);
        {r_valid_i, r_ready_i, r_last_i} = 3'b000;
        check("cancel_nodone", done_o, 0);
        check("r_empty_cnt", ar_cnt_o, 0);

        // Idle bus switch 0->1.
        bypass_req_i = 1'b1;
        tick();
        check("idle_c1_busy", busy_o, 1);
        check("idle_c1_bypass", bypass_o, 0);
        tick();
        check("idle_c2_bypass", bypass_o, 0);
        tick();
        check("idle_c3_bypass", bypass_o, 1);
        check("idle_c3_busy", busy_o, 1);
        expect_settle_done("idle");

        // Three writes outstanding, then switch 1->0.
        mst_aw_valid_i = 1'b1;
        slv_aw_ready_i = 1'b1;
        tick(3);
        mst_aw_valid_i = 1'b0;
        check("aw3_cnt", aw_cnt_o, 3);
        bypass_req_i = 1'b0;
        tick();
        mst_aw_valid_i = 1'b1;
        #1;
        check("aw3_blk_valid", slv_aw_valid_o, 0);
        check("aw3_blk_ready", mst_aw_ready_o, 0);
        mst_aw_valid_i = 1'b0;
        {b_valid_i, b_ready_i} = 2'b11;
        tick(2);
        check("aw3_b2_cnt", aw_cnt_o, 1);
        tick();
        {b_valid_i, b_ready_i} = 2'b00;
        check("aw3_b3_cnt", aw_cnt_o, 0);
        check("aw3_b3_bypass", bypass_o, 1);
        tick();
        check("aw3_switch_bypass", bypass_o, 1);
        tick();
        check("aw3_flip_bypass", bypass_o, 0);
        expect_settle_done("aw3");

        // Stalled AW when the request arrives keeps valid until its handshake.
        slv_aw_ready_i = 1'b0;
        mst_aw_valid_i = 1'b1;
        bypass_req_i = 1'b1;
        #1;
        check("stall_valid0", slv_aw_valid_o, 1);
        tick();
        check("stall_busy", busy_o, 1);
        check("stall_valid1", slv_aw_valid_o, 1);
        tick(2);
        check("stall_valid3", slv_aw_valid_o, 1);
        check("stall_cnt0", aw_cnt_o, 0);
        slv_aw_ready_i = 1'b1;
        #1;
        check("stall_ready", mst_aw_ready_o, 1);
        tick();
        mst_aw_valid_i = 1'b0;
        slv_aw_ready_i = 1'b0;
        check("stall_cnt1", aw_cnt_o, 1);
        mst_aw_valid_i = 1'b1;
        #1;
        check("stall_closed", slv_aw_valid_o, 0);
        mst_aw_valid_i = 1'b0;
        tick(2);
        check("stall_wait_bypass", bypass_o, 0);
        {b_valid_i, b_ready_i} = 2'b11;
        tick();
        {b_valid_i, b_ready_i} = 2'b00;
        tick(2);
        check("stall_flip_bypass", bypass_o, 1);
        expect_settle_done("stall");

        // Reset in SETTLE of a 1->0->1 pair lands back on the reset mode.
        bypass_req_i = 1'b0;
        tick(3);
        check("rstseq_flip0", bypass_o, 0);
        expect_settle_done("rstseq0");
        bypass_req_i = 1'b1;
        tick(4);
        check("rstseq_flip1", bypass_o, 1);
        check("rstseq_settle_busy", busy_o, 1);
        rst_i = 1'b1;
        bypass_req_i = 1'b0;
        tick();
        check("rstmid_bypass", bypass_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_done", done_o, 0);
        check("rstmid_aw_cnt", aw_cnt_o, 0);
        check("rstmid_ar_cnt", ar_cnt_o, 0);
        rst_i = 1'b0;
        tick(6);
        check("rstmid_nodone", done_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
